// File: rtl/rbcp_pkg.sv
// Shared RBCP definitions: bus widths and the offset-decode result used by register banks.
package rbcp_pkg;

    localparam int RBCP_AW = 32;
    localparam int RBCP_DW = 8;

    typedef enum logic [1:0] {
        SEL_RW    = 2'd0,
        SEL_RO    = 2'd1,
        SEL_PULSE = 2'd2,
        SEL_NONE  = 2'd3
    } rbcp_sel_e;

    // Offsets below the bank base wrap to large values and fall out as SEL_NONE.
    function automatic rbcp_sel_e rbcp_decode(input logic [RBCP_AW-1:0] off,
                                              input int unsigned n_rw,
                                              input int unsigned n_ro);
        rbcp_sel_e sel;
        if (off < n_rw)
            sel = SEL_RW;
        else if (off < n_rw + n_ro)
            sel = SEL_RO;
        else if (off == n_rw + n_ro)
            sel = SEL_PULSE;
        else
            sel = SEL_NONE;
        return sel;
    endfunction

endpackage

// File: rtl/rbcp_pulse_gen.sv
// One stretched command pulse: a load (re)arms a down-counter, output is high while it is nonzero.
module rbcp_pulse_gen #(
    parameter logic [7:0] PULSE_LEN = 8'd4
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic pulse
);

    localparam logic [7:0] LOAD_VAL = (PULSE_LEN == 8'd0) ? 8'd1 : PULSE_LEN;

    logic [7:0] cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt_q <= '0;
        else if (load)
            cnt_q <= LOAD_VAL;
        else if (cnt_q != 8'd0)
            cnt_q <= cnt_q - 8'd1;
    end

    assign pulse = (cnt_q != 8'd0);

endmodule

// File: rtl/rbcp_reg_bank.sv
// RBCP byte register bank: RW registers, RO status bytes and self-clearing command pulses.
// Optional build macro RBCP_SNAPSHOT_EN: reading the first RO offset latches all RO inputs into a shadow.
module rbcp_reg_bank
    import rbcp_pkg::*;
#(
    parameter logic [31:0]       BASE_ADDR = 32'h0000_0100,
    parameter int                N_RW      = 16,
    parameter int                N_RO      = 8,
    parameter int                N_PULSE   = 8,
    parameter logic [7:0]        PULSE_LEN = 8'd4,
    parameter logic [8*N_RW-1:0] RW_RESET  = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RBCP_ACT,
    input  logic [RBCP_AW-1:0]   RBCP_ADDR,
    input  logic [RBCP_DW-1:0]   RBCP_WD,
    input  logic                 RBCP_WE,
    input  logic                 RBCP_RE,
    output logic                 RBCP_ACK,
    output logic [RBCP_DW-1:0]   RBCP_RD,
    output logic [8*N_RW-1:0]    REG_RW_OUT,
    output logic [N_RW-1:0]      WR_STROBE,
    input  logic [8*N_RO-1:0]    REG_RO_IN,
    output logic [N_PULSE-1:0]   PULSE_OUT
);

    localparam logic [31:0] RO_BASE = 32'(N_RW);

    logic [RBCP_AW-1:0] offset;
    rbcp_sel_e          sel;
    logic               accept, do_wr, do_rd;
    logic               ack_q;
    logic [7:0]         rd_q, rd_next;
    logic [8*N_RW-1:0]  rw_q;
    logic [N_RW-1:0]    strobe_q;
    logic [8*N_RO-1:0]  ro_view;

    assign offset = RBCP_ADDR - BASE_ADDR;
    assign sel    = rbcp_decode(offset, N_RW, N_RO);

    // Strobes during the ACK cycle are dropped; WE wins over RE.
    assign accept = RBCP_ACT & (RBCP_WE | RBCP_RE) & (sel != SEL_NONE) & ~ack_q;
    assign do_wr  = accept & RBCP_WE;
    assign do_rd  = accept & RBCP_RE & ~RBCP_WE;

`ifdef RBCP_SNAPSHOT_EN
    logic [8*N_RO-1:0] shadow_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            shadow_q <= '0;
        else if (do_rd && sel == SEL_RO && offset == RO_BASE)
            shadow_q <= REG_RO_IN;
    end

    always_comb begin
        ro_view      = shadow_q;
        ro_view[7:0] = REG_RO_IN[7:0];
    end
`else
    assign ro_view = REG_RO_IN;
`endif

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_RW; i++)
            if (sel == SEL_RW && offset == 32'(i))
                rd_next = rw_q[i*8 +: 8];
        for (int j = 0; j < N_RO; j++)
            if (sel == SEL_RO && offset == 32'(N_RW + j))
                rd_next = ro_view[j*8 +: 8];
        if (sel == SEL_PULSE)
            rd_next = 8'(PULSE_OUT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_q    <= 1'b0;
            rd_q     <= '0;
            rw_q     <= RW_RESET;
            strobe_q <= '0;
        end else begin
            ack_q <= accept;
            rd_q  <= do_rd ? rd_next : 8'h00;
            for (int i = 0; i < N_RW; i++) begin
                strobe_q[i] <= do_wr && sel == SEL_RW && offset == 32'(i);
                if (do_wr && sel == SEL_RW && offset == 32'(i))
                    rw_q[i*8 +: 8] <= RBCP_WD;
            end
        end
    end

    for (genvar k = 0; k < N_PULSE; k++) begin : g_pulse
        rbcp_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_pulse (
            .CLK   (CLK),
            .RST   (RST),
            .load  (do_wr && sel == SEL_PULSE && RBCP_WD[k]),
            .pulse (PULSE_OUT[k])
        );
    end

    assign RBCP_ACK   = ack_q;
    assign RBCP_RD    = rd_q;
    assign REG_RW_OUT = rw_q;
    assign WR_STROBE  = strobe_q;

endmodule

// File: doc/rbcp_reg_bank.md
RBCP_REG_BANK -- requirements
Module: rbcp_reg_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0100: first RBCP address decoded by this bank.
REQ-002 SHALL have parameter N_RW, default 16: number of read/write byte registers (1..64).
REQ-003 SHALL have parameter N_RO, default 8: number of read-only status byte registers (1..64).
REQ-004 SHALL have parameter N_PULSE, default 8: number of self-clearing command pulse bits (1..8).
REQ-005 SHALL have parameter PULSE_LEN, default 8'd4: pulse width in CLK cycles; 0 is treated as 1.
REQ-006 SHALL have parameter RW_RESET, default all-zero, width 8*N_RW: reset value of the RW registers.
REQ-007 SHALL have port CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port RST, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port RBCP_ACT, input, 1: RBCP transaction active.
REQ-010 SHALL have port RBCP_ADDR, input, 32: byte address.
REQ-011 SHALL have port RBCP_WD, input, 8: write data.
REQ-012 SHALL have port RBCP_WE, input, 1: write-enable strobe.
REQ-013 SHALL have port RBCP_RE, input, 1: read-enable strobe.
REQ-014 SHALL have port RBCP_ACK, output, 1: access acknowledge.
REQ-015 SHALL have port RBCP_RD, output, 8: read data; 8'h00 whenever RBCP_ACK is low.
REQ-016 SHALL have port REG_RW_OUT, output, 8*N_RW: RW register contents; byte i is offset i.
REQ-017 SHALL have port WR_STROBE, output, N_RW: one-cycle pulse on bit i when RW register i is written.
REQ-018 SHALL have port REG_RO_IN, input, 8*N_RO: status bytes; byte j is offset N_RW+j.
REQ-019 SHALL have port PULSE_OUT, output, N_PULSE: stretched command pulses.

Function
REQ-020 SHALL decode offset = RBCP_ADDR-BASE_ADDR as unsigned 32-bit: RW at 0..N_RW-1, RO at N_RW..N_RW+N_RO-1, PULSE at N_RW+N_RO; an address below BASE_ADDR or above the PULSE offset is out of range.
REQ-021 SHALL act on RBCP_WE/RBCP_RE only while RBCP_ACT=1 and the address is in range; otherwise ACK stays 0 and no state changes.
REQ-022 SHALL assert RBCP_ACK for exactly one cycle, registered, on the edge after the accepted strobe.
REQ-023 SHALL update a RW register, and pulse its WR_STROBE bit, on the same edge RBCP_ACK rises.
REQ-024 SHALL, on a write to the PULSE offset, load counter k with PULSE_LEN for each RBCP_WD[k]=1, k<N_PULSE; PULSE_OUT[k]=1 while counter k is nonzero; counter decrements each cycle; a write while active reloads (retrigger); bits k>=N_PULSE are ignored.
REQ-025 SHALL return, on a read of PULSE, {zeros, PULSE_OUT}; a read of RW returns the stored byte.
REQ-026 SHALL give WE priority when WE and RE are both 1: the write is performed, ACK is asserted once, and RD=8'h00.
REQ-027 SHALL ignore strobes arriving in the cycle ACK is high; no queueing.

Reset
REQ-028 SHALL, while RST=0, force RBCP_ACK=0, RBCP_RD=8'h00, REG_RW_OUT=RW_RESET, WR_STROBE=0, PULSE_OUT=0, all pulse counters=0, snapshot shadow=0; an access in flight is dropped without ACK.
REQ-029 SHALL release cleanly: the first strobe on or after the first edge with RST=1 is accepted normally.

Configuration
REQ-030 SHALL, with RBCP_SNAPSHOT_EN defined, copy all of REG_RO_IN into a shadow register when offset N_RW is read and return live byte 0; reads of RO offsets N_RW+1.. return shadow bytes (coherent multi-byte counters).
REQ-031 SHALL, without RBCP_SNAPSHOT_EN, omit the shadow register; every RO read returns REG_RO_IN sampled in the strobe cycle.

Structure
REQ-032 SHALL take RBCP address/data widths and the offset-decode result enum (RW, RO, PULSE, NONE) from shared package rbcp_pkg.
REQ-033 SHALL instantiate sub-module rbcp_pulse_gen once per pulse bit (load, PULSE_LEN counter, output).

Verification
REQ-034 SHALL cover: write 0x5A to 0x103 with ACT=1 -> ACK one cycle later, REG_RW_OUT byte 3=0x5A, WR_STROBE[3] one cycle; read 0x103 -> RD=0x5A.
REQ-035 SHALL cover: read 0x0FF and 0x119 (defaults) -> no ACK, RD=0x00, no state change.
REQ-036 SHALL cover: write 0x81 to 0x118 -> PULSE_OUT[0] and [7] high exactly 4 cycles; rewrite 0x01 after 2 cycles -> bit 0 high 6 cycles total.
REQ-037 SHALL cover: with RBCP_SNAPSHOT_EN, REG_RO_IN bytes 0..1 = 0x00FF; read 0x110 -> 0xFF; change input to 0x0100; read 0x111 -> 0x00 (shadow); without the macro -> 0x01.
REQ-038 SHALL cover: WE and RE together at 0x100 with WD=0x33 -> single ACK, byte 0=0x33, RD=0x00.
REQ-039 SHALL cover: RST low in the cycle after a write strobe -> no ACK, all outputs at reset values.
